// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the register_bank slice.
//   DATA_W    - register width in bits
//   NUM_REGS  - number of registers (one select strobe bit per register)
//   REG_IDX_W - width of a binary register index
//   R0_IDX    - index of R0, whose read term is masked by BA_out
//   LINK_IDX  - index of the jal link register (written like any other)
//   onehot_violation(vec) - 1 when more than one bit of vec is set
package rf_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;

  localparam int R0_IDX   = 0;
  localparam int LINK_IDX = 15;

  // Popcount > 1 test for a select strobe vector.
  function automatic logic onehot_violation(input logic [NUM_REGS-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (vec[i]) begin
        cnt = cnt + 1;
      end else begin
        cnt = cnt + 0;
      end
    end
    return (cnt > 1) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/rf_onehot_check.sv
// rf_onehot_check: combinational multi-hot detector for a strobe vector.
// Ports:
//   vec       in  N  select strobe vector
//   multi_hot out 1  high when more than one bit of vec is set
module rf_onehot_check #(
  parameter int N = rf_pkg::NUM_REGS
) (
  input  logic [N-1:0] vec,
  output logic         multi_hot
);
  import rf_pkg::*;

  generate
    if (N == NUM_REGS) begin : g_pkg_fn
      assign multi_hot = onehot_violation(vec);
    end else begin : g_generic
      // Clearing the lowest set bit leaves something only if 2+ bits were set.
      assign multi_hot = |(vec & (vec - {{(N-1){1'b0}}, 1'b1}));
    end
  endgenerate

endmodule

// File: rtl/register_bank.sv
// register_bank: NUM_REGS x DATA_W general-purpose register file.
// Writes are captured on the rising clock edge for every set Rin_cs bit;
// reads are a combinational OR of the registers selected by Rout_cs, with
// R0's term forced to zero while BA_out is high. Sticky flags record any
// multi-hot Rin_cs / Rout_cs seen on a clock edge.
// Optional macro RF_BYPASS_EN: when defined, a register that is written and
// read in the same cycle contributes BusMuxOut (write-through) to reg_out.
// Ports:
//   clock     in  1         rising-edge clock
//   clear_n   in  1         asynchronous active-low reset
//   Rin_cs    in  NUM_REGS  one-hot write strobes
//   Rout_cs   in  NUM_REGS  one-hot read strobes
//   BA_out    in  1         zero R0's read contribution
//   BusMuxOut in  DATA_W    write data
//   err_clr   in  1         synchronous clear of both sticky error flags
//   reg_out   out DATA_W    selected register value
//   rin_err   out 1         sticky multi-hot Rin_cs flag
//   rout_err  out 1         sticky multi-hot Rout_cs flag
//   reg_valid out NUM_REGS  bit i set once R[i] written since reset
module register_bank #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic [NUM_REGS-1:0] Rin_cs,
  input  logic [NUM_REGS-1:0] Rout_cs,
  input  logic                BA_out,
  input  logic [DATA_W-1:0]   BusMuxOut,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   reg_out,
  output logic                rin_err,
  output logic                rout_err,
  output logic [NUM_REGS-1:0] reg_valid
);
  import rf_pkg::*;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q;
  logic [NUM_REGS-1:0] valid_d;
  logic                rin_err_q;
  logic                rin_err_d;
  logic                rout_err_q;
  logic                rout_err_d;
  logic                rin_multi_s;
  logic                rout_multi_s;

  rf_onehot_check #(.N(NUM_REGS)) u_rin_check (
    .vec       (Rin_cs),
    .multi_hot (rin_multi_s)
  );

  rf_onehot_check #(.N(NUM_REGS)) u_rout_check (
    .vec       (Rout_cs),
    .multi_hot (rout_multi_s)
  );

  // Next-state: every strobed register takes the bus (no priority on multi-hot).
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (Rin_cs[i]) begin
        regs_d[i] = BusMuxOut;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    valid_d = valid_q | Rin_cs;
  end

  // Sticky flags: a new violation outranks err_clr on the same edge.
  always_comb begin
    if (rin_multi_s) begin
      rin_err_d = 1'b1;
    end else if (err_clr) begin
      rin_err_d = 1'b0;
    end else begin
      rin_err_d = rin_err_q;
    end
    if (rout_multi_s) begin
      rout_err_d = 1'b1;
    end else if (err_clr) begin
      rout_err_d = 1'b0;
    end else begin
      rout_err_d = rout_err_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      valid_q    <= '0;
      rin_err_q  <= 1'b0;
      rout_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      valid_q    <= valid_d;
      rin_err_q  <= rin_err_d;
      rout_err_q <= rout_err_d;
    end
  end

  // Read mux: OR of selected terms; BA_out masking of R0 wins over bypass.
  always_comb begin
    logic [DATA_W-1:0] term;
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef RF_BYPASS_EN
      if (Rin_cs[i]) begin
        term = BusMuxOut;
      end else begin
        term = regs_q[i];
      end
`else
      term = regs_q[i];
`endif
      if ((i == R0_IDX) && BA_out) begin
        term = '0;
      end else begin
        term = term;
      end
      if (Rout_cs[i]) begin
        reg_out = reg_out | term;
      end else begin
        reg_out = reg_out;
      end
    end
  end

  assign rin_err   = rin_err_q;
  assign rout_err  = rout_err_q;
  assign reg_valid = valid_q;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

  logic        clock = 1'b0;
  logic        clear_n = 1'b1;
  logic [15:0] Rin_cs = 16'h0000;
  logic [15:0] Rout_cs = 16'h0000;
  logic        BA_out = 1'b0;
  logic [31:0] BusMuxOut = 32'h0;
  logic        err_clr = 1'b0;
  logic [31:0] reg_out;
  logic        rin_err;
  logic        rout_err;
  logic [15:0] reg_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic check_en = 1'b0;

  register_bank dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .Rin_cs    (Rin_cs),
    .Rout_cs   (Rout_cs),
    .BA_out    (BA_out),
    .BusMuxOut (BusMuxOut),
    .err_clr   (err_clr),
    .reg_out   (reg_out),
    .rin_err   (rin_err),
    .rout_err  (rout_err),
    .reg_valid (reg_valid)
  );

  always #5 clock = ~clock;

  // Behavioural model: register contents, written flags and sticky errors.
  logic [31:0] m_r [16];
  logic [15:0] m_valid;
  logic        m_rin_err;
  logic        m_rout_err;

  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int k = 0; k < 16; k++) m_r[k] <= 32'h0;
      m_valid    <= 16'h0;
      m_rin_err  <= 1'b0;
      m_rout_err <= 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) if (Rin_cs[k]) m_r[k] <= BusMuxOut;
      m_valid <= m_valid | Rin_cs;
      if ($countones(Rin_cs) > 1) m_rin_err <= 1'b1;
      else if (err_clr) m_rin_err <= 1'b0;
      if ($countones(Rout_cs) > 1) m_rout_err <= 1'b1;
      else if (err_clr) m_rout_err <= 1'b0;
    end
  end

  function automatic logic [31:0] exp_out();
    logic [31:0] acc;
    logic [31:0] v;
    acc = 32'h0;
    for (int k = 0; k < 16; k++) begin
      if (Rout_cs[k] && !(k == 0 && BA_out)) begin
        v = m_r[k];
`ifdef RF_BYPASS_EN
        if (Rin_cs[k]) v = BusMuxOut;
`endif
        acc = acc | v;
      end
    end
    return acc;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (check_en) begin
      chk("model_reg_out", reg_out, exp_out());
      chk("model_valid", {16'h0, reg_valid}, {16'h0, m_valid});
      chk("model_rin_err", {31'h0, rin_err}, {31'h0, m_rin_err});
      chk("model_rout_err", {31'h0, rout_err}, {31'h0, m_rout_err});
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    // Reset then read
    #1 clear_n = 1'b0;
    Rout_cs = 16'h0004;
    check_en = 1'b1;
    #2;
    chk("rst_reg_out", reg_out, 32'h0);
    chk("rst_valid", {16'h0, reg_valid}, 32'h0);
    chk("rst_rin_err", {31'h0, rin_err}, 32'h0);
    chk("rst_rout_err", {31'h0, rout_err}, 32'h0);
    tick();
    tick();
    clear_n = 1'b1;

    // Write then read R5
    Rout_cs = 16'h0000; Rin_cs = 16'h0020; BusMuxOut = 32'hDEADBEEF;
    tick();
    Rin_cs = 16'h0000; Rout_cs = 16'h0020;
    #1;
    chk("wr_read", reg_out, 32'hDEADBEEF);
    chk("wr_valid", {16'h0, reg_valid}, 32'h0000_0020);

    // BA_out masks R0
    Rout_cs = 16'h0000; Rin_cs = 16'h0001; BusMuxOut = 32'h12345678;
    tick();
    Rin_cs = 16'h0000; Rout_cs = 16'h0001; BA_out = 1'b1;
    #1;
    chk("ba_r0_zero", reg_out, 32'h0);
    BA_out = 1'b0;
    #1;
    chk("ba_r0_val", reg_out, 32'h12345678);

    // Same-cycle read/write of R3
    tick();
    Rout_cs = 16'h0000; Rin_cs = 16'h0008; BusMuxOut = 32'h1;
    tick();
    Rout_cs = 16'h0008; BusMuxOut = 32'h2;
    #1;
`ifdef RF_BYPASS_EN
    chk("rw_same_cycle", reg_out, 32'h2);
`else
    chk("rw_same_cycle", reg_out, 32'h1);
`endif
    tick();
    Rin_cs = 16'h0000;
    #1;
    chk("rw_next_cycle", reg_out, 32'h2);

    // Multi-hot write, error set and clear
    Rout_cs = 16'h0000; Rin_cs = 16'h0006; BusMuxOut = 32'hA5;
    tick();
    Rin_cs = 16'h0000; Rout_cs = 16'h0002;
    #1;
    chk("multi_r1", reg_out, 32'hA5);
    chk("multi_rin_err", {31'h0, rin_err}, 32'h1);
    Rout_cs = 16'h0004;
    #1;
    chk("multi_r2", reg_out, 32'hA5);
    Rout_cs = 16'h0006;
    #1;
    chk("multi_or_read", reg_out, 32'hA5);
    Rout_cs = 16'h0000;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("errclr_rin", {31'h0, rin_err}, 32'h0);
    err_clr = 1'b1; Rout_cs = 16'h8001;
    #1;
    chk("multi_read_r15_r0", reg_out, 32'h12345678);
    tick();
    err_clr = 1'b0; Rout_cs = 16'h0000;
    #1;
    chk("set_beats_clr", {31'h0, rout_err}, 32'h1);
    chk("valid_accum", {16'h0, reg_valid}, 32'h0000_002F);

    // Async reset mid-stream on R7
    Rin_cs = 16'h0080; BusMuxOut = 32'hFFFF0000;
    tick();
    Rin_cs = 16'h0000; Rout_cs = 16'h0080;
    #1;
    chk("r7_written", reg_out, 32'hFFFF0000);
    #1 clear_n = 1'b0;
    #1;
    chk("async_rst_out", reg_out, 32'h0);
    chk("async_rst_valid", {16'h0, reg_valid}, 32'h0);
    chk("async_rst_rout_err", {31'h0, rout_err}, 32'h0);
    tick();
    // First edge after release performs a normal write
    clear_n = 1'b1; Rin_cs = 16'h0080; BusMuxOut = 32'h5;
    tick();
    Rin_cs = 16'h0000;
    #1;
    chk("post_rst_write", reg_out, 32'h5);
    chk("post_rst_valid", {16'h0, reg_valid}, 32'h0000_0080);
    tick();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- 16 x 32-bit general-purpose register file for the RISC datapath.
- Consumes the per-register one-hot strobes produced by the register-select logic: Rin_cs writes, Rout_cs reads.
- Reads drive the bus mux; writes capture BusMuxOut on the clock edge.
- Sticky one-hot violation flags catch control-unit or selector faults during bring-up.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of registers; one strobe bit per register.

Ports:
- clock  in  1  system clock; rising-edge active.
- clear_n  in  1  asynchronous active-low reset.
- Rin_cs  in  NUM_REGS  one-hot write strobes; bit i writes R[i].
- Rout_cs  in  NUM_REGS  one-hot read strobes; bit i drives R[i] onto reg_out.
- BA_out  in  1  base-address read; when high, R0 contributes zero to reg_out.
- BusMuxOut  in  DATA_W  write data.
- err_clr  in  1  synchronous clear of both sticky error flags.
- reg_out  out  DATA_W  selected register value to the bus mux.
- rin_err  out  1  sticky: more than one Rin_cs bit was set on a clock edge.
- rout_err  out  1  sticky: more than one Rout_cs bit was set on a clock edge.
- reg_valid  out  NUM_REGS  bit i set once R[i] has been written since reset.

Behaviour:
- Reset: clear_n low asynchronously forces all R[i], rin_err, rout_err and reg_valid to 0. reg_out then reads 0.
- Reset released mid-operation: the first rising edge with clear_n high performs normal writes.
- Write, 1-cycle latency: at the rising edge, every i with Rin_cs[i]=1 takes R[i] <= BusMuxOut and sets reg_valid[i] <= 1.
- Multi-hot Rin_cs: all selected registers are written (no priority). rin_err is set on that same edge.
- Read, combinational, 0 latency: reg_out = OR over i of (Rout_cs[i] ? R[i] : 0).
  - R0's term is forced to 0 when BA_out=1.
  - Rout_cs all-zero gives reg_out = 0.
  - Multi-hot Rout_cs gives the bitwise OR of the selected registers; rout_err is set at the next rising edge while the condition holds.
- Read/write same register, same cycle: reg_out shows the old value; the new value is visible the next cycle (unless RF_BYPASS_EN).
- Error flags:
  - Cleared only by reset or err_clr=1 at a clock edge.
  - If err_clr and a new violation occur at the same edge, the set wins.
- No state machine: storage is purely edge-written registers plus sticky flags.
- R15 has no special write path here; jal link write arrives as Rin_cs[15].

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through bypass. If Rin_cs[i]=1 and Rout_cs[i]=1 in the same cycle, R[i]'s term in reg_out is BusMuxOut rather than the stored value.
  - The BA_out zeroing of R0 still takes precedence.
- Undefined: reads always return stored values, as described in Behaviour.

Decomposition:
- Shared package, rf_pkg:
  - constants DATA_W=32, NUM_REGS=16, REG_IDX_W=4;
  - named indices R0_IDX=0 and LINK_IDX=15;
  - function onehot_violation(vec), returning 1 when popcount>1.
- One natural sub-module, rf_onehot_check: takes a NUM_REGS vector, outputs a multi-hot flag. Instantiated twice (Rin, Rout).

Test Plan:
- Reset then read: clear_n low, Rout_cs=16'h0004 -> reg_out=0, reg_valid=0, both error flags 0.
- Write and read: BusMuxOut=32'hDEADBEEF, Rin_cs=16'h0020 for one edge; then Rout_cs=16'h0020 -> reg_out=32'hDEADBEEF, reg_valid=16'h0020.
- BA_out on R0: R0=32'h12345678 written; Rout_cs=16'h0001, BA_out=1 -> reg_out=0; BA_out=0 -> 32'h12345678.
- Same-cycle read/write: R3=32'h1, then Rin_cs=Rout_cs=16'h0008, BusMuxOut=32'h2 -> reg_out=32'h1 without RF_BYPASS_EN, 32'h2 with it; both builds read 32'h2 the next cycle.
- Multi-hot: Rin_cs=16'h0006, BusMuxOut=32'hA5 -> R1=R2=32'hA5 and rin_err=1. Then err_clr for one edge -> rin_err=0. Then err_clr together with Rout_cs=16'h8001 -> rout_err=1.
- Async reset mid-stream: R7 written with 32'hFFFF0000; clear_n pulsed low between edges -> R7=0 immediately, reg_out=0 with Rout_cs=16'h0080.
